// File: rtl/iperm_kp_seq.sv
// iperm_kp_seq: expands {sel, cnt, step} permutation commands into a stream
// of per-beat key tokens (i_kp_*) for the input-permutation control stage.
// A command yields cnt+1 tokens; the selector either holds or advances
// modulo NSEL each beat. A new command can be loaded on the final-token
// handshake, so back-to-back commands run with no bubble.
//
// Handshake rule for both interfaces: a transfer happens in a cycle where
// req and ack are both high. i_kp_req/ctrl/last are registered and hold
// while i_kp_req=1 and i_kp_ack=0. t_cmd_ack never looks at t_cmd_req.
//
// Optional build macro IPERM_KP_SEQ_STATS_EN adds stat_tokens/stat_cmds.
module iperm_kp_seq #(
  parameter int SELW = 4,
  parameter int CNTW = 8,
  parameter int NSEL = 9
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            t_cmd_req,
  output logic            t_cmd_ack,
  input  logic [SELW-1:0] t_cmd_sel,
  input  logic [CNTW-1:0] t_cmd_cnt,
  input  logic            t_cmd_step,
  input  logic            t_abort,
  output logic            i_kp_req,
  input  logic            i_kp_ack,
  output logic [SELW-1:0] i_kp_ctrl,
  output logic            i_kp_last
`ifdef IPERM_KP_SEQ_STATS_EN
  ,
  output logic [31:0]     stat_tokens,
  output logic [15:0]     stat_cmds
`endif
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [SELW-1:0] SEL_MAX = SELW'(NSEL - 1);

  state_t          state;
  logic [CNTW-1:0] remaining;
  logic            step_mode;
  logic            cmd_take;
  logic            tok_take;
  logic [SELW-1:0] ctrl_next;

  // Commands are taken in IDLE, or in RUN on the final-token handshake.
  // Abort and reset both block acceptance.
  assign t_cmd_ack = reset_n && !t_abort &&
                     ((state == IDLE) || (i_kp_last && i_kp_ack));
  assign cmd_take  = t_cmd_req && t_cmd_ack;
  assign tok_take  = i_kp_req && i_kp_ack;

  // Out-of-range selectors count up with natural 2^SELW wrap until they
  // reach NSEL-1, after which the modulo wrap takes over.
  assign ctrl_next = (i_kp_ctrl == SEL_MAX) ? '0 : i_kp_ctrl + 1'b1;

  // Sequencer FSM: reset > abort > command load > token advance.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      remaining <= '0;
      step_mode <= 1'b0;
      i_kp_req  <= 1'b0;
      i_kp_ctrl <= '0;
      i_kp_last <= 1'b0;
    end else if (t_abort) begin
      state     <= IDLE;
      remaining <= '0;
      i_kp_req  <= 1'b0;
      i_kp_last <= 1'b0;
    end else if (cmd_take) begin
      state     <= RUN;
      remaining <= t_cmd_cnt;
      step_mode <= t_cmd_step;
      i_kp_req  <= 1'b1;
      i_kp_ctrl <= t_cmd_sel;
      i_kp_last <= (t_cmd_cnt == '0);
    end else if ((state == RUN) && i_kp_ack) begin
      if (remaining != '0) begin
        remaining <= remaining - 1'b1;
        i_kp_last <= (remaining == CNTW'(1));
        if (step_mode) begin
          i_kp_ctrl <= ctrl_next;
        end
      end else begin
        // Final token delivered and no follow-on command.
        state     <= IDLE;
        i_kp_req  <= 1'b0;
        i_kp_last <= 1'b0;
      end
    end
  end

`ifdef IPERM_KP_SEQ_STATS_EN
  // Delivered-token and accepted-command counters; wrap on overflow.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_tokens <= '0;
      stat_cmds   <= '0;
    end else begin
      if (tok_take) stat_tokens <= stat_tokens + 32'd1;
      if (cmd_take) stat_cmds   <= stat_cmds + 16'd1;
    end
  end
`else
  logic unused_tok;
  assign unused_tok = tok_take;
`endif

endmodule
